// File: rtl/freq_div_ctrl_pkg.sv
// freq_div_ctrl_pkg: state encoding and ratio floor shared by the divider controller and its benches
package freq_div_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  localparam int MIN_DIV = 2;
endpackage

// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: holds the divide ratio and emits a glitch-free divided enable waveform
module freq_div_ctrl
  import freq_div_ctrl_pkg::*;
#(
  parameter int W       = 8,
  parameter int DEF_DIV = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         div_out,
  output logic         tick,
  output logic         busy,
  output logic [W-1:0] cur_div
);
  state_t         state, state_n;
  logic [W-1:0]   cnt, cnt_n, cur_div_n, pend, pend_n;
  logic           pend_vld, pend_vld_n, acc, legal, wrap, run_n;
  logic [W:0]     half;
  always_comb begin
    acc        = cfg_valid & cfg_ready;
    legal      = cfg_div >= W'(MIN_DIV);
    wrap       = (state != IDLE) && (cnt == cur_div - W'(1));
    state_n    = state;
    cnt_n      = cnt;
    cur_div_n  = cur_div;
    pend_n     = pend;
    pend_vld_n = pend_vld;
    if (state == IDLE) begin
      cur_div_n = (acc & legal) ? cfg_div : cur_div;
      cnt_n     = '0;
      state_n   = en ? RUN : IDLE;
    end else if (wrap) begin
      // an offer landing on the boundary bypasses the pending slot
      cur_div_n  = (acc & legal) ? cfg_div : pend_vld ? pend : cur_div;
      pend_vld_n = 1'b0;
      cnt_n      = '0;
      state_n    = en ? RUN : IDLE;
    end else begin
      cnt_n   = cnt + W'(1);
      state_n = en ? RUN : DRAIN;
      if (acc & legal) begin
        pend_n     = cfg_div;
        pend_vld_n = 1'b1;
      end
    end
    run_n = state_n != IDLE;
    half  = ({1'b0, cur_div_n} + (W+1)'(1)) >> 1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_div   <= W'(DEF_DIV);
      pend      <= '0;
      pend_vld  <= 1'b0;
      div_out   <= 1'b0;
      tick      <= 1'b0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cur_div   <= cur_div_n;
      pend      <= pend_n;
      pend_vld  <= pend_vld_n;
      div_out   <= run_n && ({1'b0, cnt_n} < half);
      tick      <= run_n && (cnt_n == '0);
      cfg_ready <= ~pend_vld_n;
      cfg_err   <= acc & ~legal;
      busy      <= run_n;
    end
  end
endmodule

// File: tb/tb_freq_div_ctrl.sv
// tb_freq_div_ctrl: directed literal checks plus randomized traffic against a period-level model
module tb_freq_div_ctrl;
  localparam int W = 8;
  logic         clk = 0, rst = 0, en = 0, cfg_valid = 0;
  logic [W-1:0] cfg_div = '0;
  logic         cfg_ready, cfg_err, div_out, tick, busy;
  logic [W-1:0] cur_div;
  int checks = 0, errors = 0;
  bit m_run = 0, m_pv = 0, e_err = 0;
  int m_p = 0, m_n = 2, m_pend = 0;

  freq_div_ctrl #(.W(W), .DEF_DIV(2)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .div_out(div_out), .tick(tick),
    .busy(busy), .cur_div(cur_div)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a period of m_n cycles, position m_p, high for the first ceil(m_n/2) positions.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_run = 0; m_pv = 0; m_p = 0; m_n = 2; e_err = 0;
      end else begin
        bit acc, ok;
        acc = cfg_valid && !m_pv;
        ok = int'(cfg_div) >= 2;
        e_err = acc && !ok;
        if (!m_run) begin
          if (acc && ok) m_n = int'(cfg_div);
          if (en) begin m_run = 1; m_p = 0; end
        end else if (m_p == m_n - 1) begin
          if (acc && ok) m_n = int'(cfg_div);
          else if (m_pv) m_n = m_pend;
          m_pv = 0;
          m_p = 0;
          if (!en) m_run = 0;
        end else begin
          m_p++;
          if (acc && ok) begin m_pend = int'(cfg_div); m_pv = 1; end
        end
      end
      #2;
      chk("div_out", div_out, int'(m_run && m_p < (m_n + 1) / 2));
      chk("tick", tick, int'(m_run && m_p == 0));
      chk("busy", busy, int'(m_run));
      chk("cfg_ready", cfg_ready, int'(!m_pv));
      chk("cfg_err", cfg_err, int'(e_err));
      chk("cur_div", cur_div, m_n);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] p4;
    logic [4:0] p5;
    step();
    chk("rst_cur_div", cur_div, 2);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_div_out", div_out, 0);
    rst = 1; en = 1;
    step();
    chk("first_tick", tick, 1);
    chk("first_busy", busy, 1);
    p4 = '0;
    for (int i = 0; i < 4; i++) begin p4 = {p4[2:0], div_out}; step(); end
    chk("n2_pattern", p4, 4'b1010);
    cfg_valid = 1; cfg_div = 8'd5;
    step();
    chk("pend_stall", cfg_ready, 0);
    chk("pend_keeps_cur", cur_div, 2);
    cfg_valid = 0;
    step();
    chk("n5_applied", cur_div, 5);
    p5 = '0;
    for (int i = 0; i < 5; i++) begin p5 = {p5[3:0], div_out}; step(); end
    chk("n5_pattern", p5, 5'b11100);
    cfg_valid = 1; cfg_div = 8'd4;
    step();
    cfg_valid = 0;
    repeat (6) step();
    cfg_valid = 1; cfg_div = 8'd1;
    step();
    cfg_valid = 0;
    chk("illegal_err", cfg_err, 1);
    chk("illegal_cur", cur_div, 4);
    step();
    chk("err_one_cycle", cfg_err, 0);
    cfg_valid = 1; cfg_div = 8'd7;
    step();
    cfg_valid = 0;
    repeat (9) step();
    #2 rst = 0;
    #1;
    chk("async_div_out", div_out, 0);
    chk("async_busy", busy, 0);
    chk("async_cur", cur_div, 2);
    chk("async_tick", tick, 0);
    step();
    rst = 1;
    step();
    chk("restart_tick", tick, 1);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 40) == 0) en = ~en;
      cfg_valid = $urandom_range(0, 5) == 0;
      cfg_div = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 9));
      step();
    end
    en = 0; cfg_valid = 0;
    repeat (300) step();
    chk("final_idle", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
